// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment constants for the clock display path.
// Patterns are active-high, abcdefg order (bit 6 = a ... bit 0 = g).
package seg7_pkg;

  // Segment bit positions within a 7-bit pattern.
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  // Digit patterns, abcdefg.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;  // segment g only

endpackage

// File: rtl/seg7_lut.sv
// seg7_lut: combinational BCD digit -> active-high segment pattern.
// Ports:
//   bcd     - 4-bit digit; 0-9 decode, 10-15 are invalid
//   pattern - abcdefg pattern, active-high; invalid codes give blank or dash
module seg7_lut
  import seg7_pkg::*;
#(
  parameter bit INVALID_DASH = 1'b0
) (
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    unique case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = INVALID_DASH ? SEG_DASH : SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: registered BCD-to-seven-segment decoder, one clock latency.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset; drives the blank pattern
//   bcd - BCD digit (0-9 valid, 10-15 invalid)
//   seg - registered segment drive, seg[6]=a ... seg[0]=g
// Parameters:
//   ACTIVE_LOW   - 1 inverts every output (including reset/blank) for common anode
//   INVALID_DASH - 1 shows a dash for invalid codes, 0 blanks them
module bcd_to_7seg
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter bit INVALID_DASH = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  localparam logic [6:0] POL_MASK = ACTIVE_LOW ? '1 : '0;

  logic [6:0] pattern;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  seg7_lut #(
    .INVALID_DASH(INVALID_DASH)
  ) u_lut (
    .bcd    (bcd),
    .pattern(pattern)
  );

  // Reset selects blank before the polarity XOR so blank inverts too.
  always_comb begin
    seg_d = (rst ? SEG_BLANK : pattern) ^ POL_MASK;
  end

  always_ff @(posedge clk) begin
    seg_q <= seg_d;
  end

  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// tb_bcd_to_7seg: scoreboard bench driving four parameter variants of
// bcd_to_7seg from shared stimulus against a segment-letter reference model.
module tb_bcd_to_7seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd = 4'd8;
  logic [6:0] seg_w [4];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef logic [3:0][6:0] exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Variant i: ACTIVE_LOW = i[1], INVALID_DASH = i[0].
  bcd_to_7seg #(.ACTIVE_LOW(1'b0), .INVALID_DASH(1'b0)) u0 (.clk(clk), .rst(rst), .bcd(bcd), .seg(seg_w[0]));
  bcd_to_7seg #(.ACTIVE_LOW(1'b0), .INVALID_DASH(1'b1)) u1 (.clk(clk), .rst(rst), .bcd(bcd), .seg(seg_w[1]));
  bcd_to_7seg #(.ACTIVE_LOW(1'b1), .INVALID_DASH(1'b0)) u2 (.clk(clk), .rst(rst), .bcd(bcd), .seg(seg_w[2]));
  bcd_to_7seg #(.ACTIVE_LOW(1'b1), .INVALID_DASH(1'b1)) u3 (.clk(clk), .rst(rst), .bcd(bcd), .seg(seg_w[3]));

  // Lit segments per digit, by letter.
  string lit [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] ref_seg(int unsigned d, bit r, bit al, bit dash);
    logic [6:0] v;
    string s;
    byte ch;
    v = 7'd0;
    if (!r) begin
      if (d < 10) begin
        s = lit[d];
        for (int k = 0; k < s.len(); k++) begin
          ch = s[k];
          v[6 - (int'(ch) - 97)] = 1'b1;
        end
      end else if (dash) begin
        v[0] = 1'b1;
      end
    end
    return al ? ~v : v;
  endfunction

  // Apply one digit mid-cycle and queue what each variant should show after the next edge.
  task automatic drive(input int unsigned d, input bit r);
    exp_t e;
    @(posedge clk);
    #3;
    bcd = 4'(d);
    rst = r;
    for (int i = 0; i < 4; i++) e[i] = ref_seg(d, r, i[1], i[0]);
    exp_q.push_back(e);
  endtask

  // Monitor: pop just after each edge, then recheck late in the cycle after
  // bcd has already moved on, so the output must hold until the next edge.
  initial begin : monitor
    exp_t cur;
    bit have;
    have = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        have = 1'b1;
        for (int i = 0; i < 4; i++) begin
          n_cmp++;
          if (seg_w[i] !== cur[i]) begin
            n_bad++;
            $display("FAIL edge u%0d: seg=%b expected=%b (t=%0t)", i, seg_w[i], cur[i], $time);
          end
        end
      end
      #6;
      if (have) begin
        for (int i = 0; i < 4; i++) begin
          n_cmp++;
          if (seg_w[i] !== cur[i]) begin
            n_bad++;
            $display("FAIL hold u%0d: seg=%b expected=%b (t=%0t)", i, seg_w[i], cur[i], $time);
          end
        end
      end
    end
  end

  initial begin : stim
    int unsigned budget;
    // Reset held two cycles with bcd=8, then release.
    drive(8, 1'b1);
    drive(8, 1'b1);
    drive(8, 1'b0);
    // Full valid sweep and invalid codes.
    for (int unsigned d = 0; d < 16; d++) drive(d, 1'b0);
    // 3 then 7: the hold check sees 3's pattern after bcd already moved to 7.
    drive(3, 1'b0);
    drive(7, 1'b0);
    // One-cycle reset mid-sweep while bcd=5, decode resumes with current bcd.
    drive(4, 1'b0);
    drive(5, 1'b1);
    drive(5, 1'b0);
    drive(6, 1'b0);
    // Randomized digits with occasional reset.
    for (int n = 0; n < 300; n++)
      drive($urandom_range(15, 0), ($urandom_range(19, 0) == 0));
    // Drain with a bounded wait.
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #8;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
